// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the i2d -> d2a -> a2w in-order pipeline.
// Hazard controls are combinational from the current state and the stage
// inputs, so they act in the same cycle. A small FSM tracks d-cache waits
// with a watchdog. Saturating counters record stall and redirect activity.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  dec_valid,
  input  logic                  dec_rs0_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs0,
  input  logic                  dec_rs1_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic                  dec_ps_read,
  input  logic                  act_valid,
  input  logic                  act_reg_write,
  input  logic [REG_ADDR_W-1:0] act_reg_addr,
  input  logic                  act_ps_write,
  input  logic                  act_mem_access,
  input  logic                  act_mem_load,
  input  logic                  dcache_ready,
  input  logic                  act_branch_taken,
  output logic                  pc_stall,
  output logic                  i2d_stall,
  output logic                  i2d_flush,
  output logic                  d2a_stall,
  output logic                  d2a_bubble,
  output logic                  a2w_bubble,
  output logic                  redirect,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count,
  output logic                  timeout_err
);

  localparam int WAIT_W = 16;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;

  logic mem_block;
  logic branch_hit;
  logic src_hit;
  logic load_use;
  logic stall_any;

  // Hazard detection terms from the decode and act stages.
  always_comb begin
    mem_block  = act_valid & act_mem_access & ~dcache_ready;
    branch_hit = act_valid & act_branch_taken;
    src_hit    = (act_reg_write &
                  ((dec_rs0_valid & (dec_rs0 == act_reg_addr)) |
                   (dec_rs1_valid & (dec_rs1 == act_reg_addr)))) |
                 (act_ps_write & dec_ps_read);
    load_use   = act_valid & act_mem_load & dcache_ready & dec_valid & src_hit;
  end

  // Prioritised pipeline controls; everything is held low while in reset.
  always_comb begin
    pc_stall   = 1'b0;
    i2d_stall  = 1'b0;
    i2d_flush  = 1'b0;
    d2a_stall  = 1'b0;
    d2a_bubble = 1'b0;
    a2w_bubble = 1'b0;
    redirect   = 1'b0;
    if (n_rst) begin
      if (state_q == ST_ERR || mem_block) begin
        // Freeze the front of the pipe and drain nothing into write-back.
        pc_stall   = 1'b1;
        i2d_stall  = 1'b1;
        d2a_stall  = 1'b1;
        a2w_bubble = 1'b1;
      end else if (branch_hit) begin
        redirect   = 1'b1;
        i2d_flush  = 1'b1;
        d2a_bubble = 1'b1;
      end else if (load_use) begin
        // One bubble; the following cycle forwards the load data from a2w.
        pc_stall   = 1'b1;
        i2d_stall  = 1'b1;
        d2a_bubble = 1'b1;
      end
    end
  end

  // Next-state logic for the d-cache wait FSM and its watchdog.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_RUN: begin
        if (mem_block) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_block) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = ST_ERR;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Saturating performance counter updates.
  always_comb begin
    stall_any      = pc_stall | d2a_stall | a2w_bubble | d2a_bubble;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_any && stall_cycles_q != CNT_MAX) begin
      stall_cycles_d = stall_cycles_q + CNT_ONE;
    end
    if (redirect && flush_count_q != CNT_MAX) begin
      flush_count_d = flush_count_q + CNT_ONE;
    end
  end

  // State, watchdog and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      timeout_err_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      timeout_err_q  <= timeout_err_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver applies directed and
// random stimulus and queues the expected response from a rule-level
// reference model; a monitor pops and compares on every falling edge.
module tb_pipe_hazard_ctrl;

  localparam int RW   = 4;
  localparam int CW   = 4;
  localparam int TOUT = 4;
  localparam int CMAX = 15;

  logic          clk;
  logic          n_rst;
  logic          dec_valid, dec_rs0_valid, dec_rs1_valid, dec_ps_read;
  logic [RW-1:0] dec_rs0, dec_rs1, act_reg_addr;
  logic          act_valid, act_reg_write, act_ps_write, act_mem_access;
  logic          act_mem_load, dcache_ready, act_branch_taken;
  logic          pc_stall, i2d_stall, i2d_flush, d2a_stall, d2a_bubble;
  logic          a2w_bubble, redirect, timeout_err;
  logic [1:0]    state;
  logic [CW-1:0] stall_cycles, flush_count;

  typedef struct packed {
    logic          rst_n;
    logic          dv;
    logic          rs0v;
    logic [RW-1:0] rs0;
    logic          rs1v;
    logic [RW-1:0] rs1;
    logic          psr;
    logic          av;
    logic          rwr;
    logic [RW-1:0] rd;
    logic          psw;
    logic          mem;
    logic          ld;
    logic          rdy;
    logic          br;
  } stim_t;

  typedef struct packed {
    logic          pc;
    logic          i2d_st;
    logic          i2d_fl;
    logic          d2a_st;
    logic          d2a_bub;
    logic          a2w_bub;
    logic          redir;
    logic [1:0]    st;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    logic          te;
  } exp_t;

  exp_t  exp_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;
  bit    done   = 0;

  // Reference model: mode 0=run, 1=waiting on d-cache, 2=error.
  int    m_mode  = 0;
  int    m_left  = 0;
  int    m_sc    = 0;
  int    m_fc    = 0;
  bit    m_te    = 0;
  stim_t last_s;

  pipe_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .MEM_TIMEOUT(TOUT)) dut (
    .clk(clk), .n_rst(n_rst),
    .dec_valid(dec_valid), .dec_rs0_valid(dec_rs0_valid), .dec_rs0(dec_rs0),
    .dec_rs1_valid(dec_rs1_valid), .dec_rs1(dec_rs1), .dec_ps_read(dec_ps_read),
    .act_valid(act_valid), .act_reg_write(act_reg_write), .act_reg_addr(act_reg_addr),
    .act_ps_write(act_ps_write), .act_mem_access(act_mem_access),
    .act_mem_load(act_mem_load), .dcache_ready(dcache_ready),
    .act_branch_taken(act_branch_taken),
    .pc_stall(pc_stall), .i2d_stall(i2d_stall), .i2d_flush(i2d_flush),
    .d2a_stall(d2a_stall), .d2a_bubble(d2a_bubble), .a2w_bubble(a2w_bubble),
    .redirect(redirect), .state(state), .stall_cycles(stall_cycles),
    .flush_count(flush_count), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model_out(input stim_t s);
    exp_t e;
    bit   blocked, hit, use_hazard;
    e = '0;
    if (!s.rst_n) return e;
    e.st = 2'(m_mode);
    e.sc = CW'(m_sc);
    e.fc = CW'(m_fc);
    e.te = m_te;
    blocked = s.av && s.mem && !s.rdy;
    hit = (s.rwr && ((s.rs0v && s.rs0 == s.rd) || (s.rs1v && s.rs1 == s.rd))) ||
          (s.psw && s.psr);
    use_hazard = s.av && s.ld && s.rdy && s.dv && hit;
    if (m_mode == 2 || blocked) begin
      e.pc = 1; e.i2d_st = 1; e.d2a_st = 1; e.a2w_bub = 1;
    end else if (s.av && s.br) begin
      e.redir = 1; e.i2d_fl = 1; e.d2a_bub = 1;
    end else if (use_hazard) begin
      e.pc = 1; e.i2d_st = 1; e.d2a_bub = 1;
    end
    return e;
  endfunction

  task automatic model_step(input stim_t s, input exp_t e);
    bit blocked;
    if (!s.rst_n) begin
      m_mode = 0; m_left = 0; m_sc = 0; m_fc = 0; m_te = 0;
      return;
    end
    blocked = s.av && s.mem && !s.rdy;
    if (e.pc || e.d2a_st || e.a2w_bub || e.d2a_bub) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
    if (e.redir) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
    if (m_mode == 0) begin
      if (blocked) begin
        m_mode = 1;
        m_left = TOUT;
      end
    end else if (m_mode == 1) begin
      if (!blocked) begin
        m_mode = 0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = 2;
          m_te   = 1;
        end
      end
    end
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    n_rst = s.rst_n;            dec_valid = s.dv;
    dec_rs0_valid = s.rs0v;     dec_rs0 = s.rs0;
    dec_rs1_valid = s.rs1v;     dec_rs1 = s.rs1;
    dec_ps_read = s.psr;        act_valid = s.av;
    act_reg_write = s.rwr;      act_reg_addr = s.rd;
    act_ps_write = s.psw;       act_mem_access = s.mem;
    act_mem_load = s.ld;        dcache_ready = s.rdy;
    act_branch_taken = s.br;
    e = model_out(s);
    exp_q.push_back(e);
    model_step(s, e);
    last_s = s;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t load(input int rd, input bit rdy);
    stim_t s;
    s = idle();
    s.av = 1; s.mem = 1; s.ld = 1; s.rwr = 1; s.rd = RW'(rd); s.rdy = rdy;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst_n = ($urandom_range(0, 39) != 0);
    s.dv    = ($urandom_range(0, 3) != 0);
    s.rs0v  = 1'($urandom_range(0, 1));
    s.rs0   = RW'($urandom_range(0, 3));
    s.rs1v  = 1'($urandom_range(0, 1));
    s.rs1   = RW'($urandom_range(0, 3));
    s.psr   = ($urandom_range(0, 3) == 0);
    s.av    = ($urandom_range(0, 3) != 0);
    s.rwr   = 1'($urandom_range(0, 1));
    s.rd    = RW'($urandom_range(0, 3));
    s.psw   = ($urandom_range(0, 3) == 0);
    s.mem   = ($urandom_range(0, 2) == 0);
    s.ld    = s.mem & 1'($urandom_range(0, 1));
    s.rdy   = 1'($urandom_range(0, 1));
    s.br    = ($urandom_range(0, 4) == 0);
    if (m_mode == 1) begin
      // The act stage is frozen while waiting; only readiness changes.
      s.av = 1; s.mem = 1; s.ld = last_s.ld; s.rwr = last_s.rwr;
      s.rd = last_s.rd; s.psw = last_s.psw; s.br = last_s.br;
      s.rdy = ($urandom_range(0, 3) == 0);
    end
    if (m_mode == 2 && $urandom_range(0, 3) == 0) s.rst_n = 1'b0;
    return s;
  endfunction

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{pc_stall, i2d_stall, i2d_flush, d2a_stall, d2a_bubble,
              a2w_bubble, redirect, state, stall_cycles, flush_count, timeout_err};
        n_vec++;
        if (g !== e) begin
          n_miss++;
          $display("FAIL vec %0d: got ctl=%b st=%0d sc=%0d fc=%0d te=%b, required ctl=%b st=%0d sc=%0d fc=%0d te=%b",
                   n_vec, g[CW*2+9:CW*2+3], g.st, g.sc, g.fc, g.te,
                   e[CW*2+9:CW*2+3], e.st, e.sc, e.fc, e.te);
        end else begin
          $display("vec %0d ok: ctl=%b st=%0d sc=%0d fc=%0d te=%b",
                   n_vec, g[CW*2+9:CW*2+3], g.st, g.sc, g.fc, g.te);
        end
      end
    end
  end

  // Driver: directed scenarios first, then randomized traffic.
  initial begin
    stim_t s;
    n_rst = 1'b0;
    {dec_valid, dec_rs0_valid, dec_rs1_valid, dec_ps_read} = '0;
    {dec_rs0, dec_rs1, act_reg_addr} = '0;
    {act_valid, act_reg_write, act_ps_write, act_mem_access} = '0;
    {act_mem_load, dcache_ready, act_branch_taken} = '0;
    last_s = '0;

    s = idle(); s.rst_n = 0;
    apply(s); apply(s);
    apply(idle());

    // Load r3 waits three cycles on the d-cache.
    for (int i = 0; i < 3; i++) apply(load(3, 0));
    apply(load(3, 1));
    apply(idle());

    // Load-use on r5 versus no dependency on r6.
    s = load(5, 1); s.dv = 1; s.rs1v = 1; s.rs1 = 5;
    apply(s);
    s.rs1 = 6;
    apply(s);

    // Taken branch outranks a simultaneous load-use hit.
    s = load(5, 1); s.dv = 1; s.rs1v = 1; s.rs1 = 5; s.br = 1; s.mem = 0;
    apply(s);
    apply(idle());

    // Watchdog: ready never comes, then arrives late; only reset clears.
    for (int i = 0; i < 8; i++) apply(load(2, 0));
    for (int i = 0; i < 2; i++) apply(load(2, 1));
    s = idle(); s.rst_n = 0;
    apply(s);
    apply(idle());

    // Reset asserted in the middle of a d-cache wait.
    for (int i = 0; i < 3; i++) apply(load(7, 0));
    s = load(7, 0); s.rst_n = 0;
    apply(s);
    apply(load(7, 1));

    // Continuous stalls saturate the stall counter.
    for (int i = 0; i < 20; i++) apply(load(1, 0));
    s = idle(); s.rst_n = 0;
    apply(s);

    for (int i = 0; i < 3000; i++) apply(rand_stim());

    // Allow the monitor to drain with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 3-register in-order pipeline (i2d, d2a, a2w).
- Watches decode-stage source operands, act-stage destination, memory and branch status, and d-cache completion.
- Generates per-register hold/bubble/flush controls plus the fetch redirect.
- Tracks d-cache waits with a state machine and watchdog, and exposes saturating performance counters.

Parameters:
REG_ADDR_W, 4, register address width
CNT_W, 16, performance counter width
MEM_TIMEOUT, 64, max MEM_WAIT cycles before timeout_err; 1..2^16-1

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
dec_valid  in  1  decode stage holds a valid instruction
dec_rs0_valid  in  1  decode reads source 0
dec_rs0  in  REG_ADDR_W  source 0 address
dec_rs1_valid  in  1  decode reads source 1
dec_rs1  in  REG_ADDR_W  source 1 address
dec_ps_read  in  1  decode reads processor status
act_valid  in  1  act stage valid
act_reg_write  in  1  act instruction writes a register
act_reg_addr  in  REG_ADDR_W  act destination
act_ps_write  in  1  act instruction writes processor status
act_mem_access  in  1  act instruction accesses d-cache
act_mem_load  in  1  access is a load
dcache_ready  in  1  d-cache completes the access this cycle
act_branch_taken  in  1  taken branch resolved in act
pc_stall  out  1  hold PC
i2d_stall  out  1  hold i2d contents
i2d_flush  out  1  load valid=0 into i2d
d2a_stall  out  1  hold d2a contents
d2a_bubble  out  1  load valid=0 into d2a
a2w_bubble  out  1  load valid=0 into a2w
redirect  out  1  fetch takes branch target
state  out  2  0=RUN, 1=MEM_WAIT, 2=ERR
stall_cycles  out  CNT_W  cycles with any stall/bubble asserted
flush_count  out  CNT_W  number of redirects
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset: async on n_rst low. state=RUN, counters=0, wait counter=0, timeout_err=0.
- While n_rst is low, all control outputs are forced to 0.
- Control outputs are combinational from state and inputs, so they take effect in the same cycle. Counters and state update on the rising clk edge.
- mem_block = act_valid & act_mem_access & ~dcache_ready.
- Priority, highest first:
  - 1. MEM block: mem_block in RUN or MEM_WAIT. Drives pc_stall=i2d_stall=d2a_stall=a2w_bubble=1, all others 0.
  - 2. Branch: act_valid & act_branch_taken. Drives redirect=i2d_flush=d2a_bubble=1; no stall.
  - 3. Load-use: act_valid & act_mem_load & dcache_ready, plus dec_valid, plus a hit. A hit is (act_reg_write & a valid decode source equals act_reg_addr) or (act_ps_write & dec_ps_read). Drives pc_stall=i2d_stall=d2a_bubble=1 for exactly that cycle. The next cycle is resolved by forwarding from a2w.
  - 4. Otherwise all controls are 0.
- No hazard is raised for non-load ALU producers; forwarding covers them.
- A branch that also asserts act_mem_access is illegal. The MEM rule wins and the branch is honoured once dcache_ready.
- State transitions:
  - RUN -> MEM_WAIT when mem_block.
  - MEM_WAIT -> RUN on the edge after dcache_ready=1. In the dcache_ready cycle the stall outputs are already 0.
  - MEM_WAIT -> ERR when the wait counter reaches MEM_TIMEOUT without ready. timeout_err is set.
  - ERR holds pc_stall=i2d_stall=d2a_stall=a2w_bubble=1 permanently. Only reset exits ERR.
- Wait counter: cleared on entry to MEM_WAIT. Increments each MEM_WAIT cycle.
- dcache_ready while state=RUN with act_mem_access means a single-cycle access: no stall, state stays RUN.
- stall_cycles increments when any of pc_stall/d2a_stall/a2w_bubble/d2a_bubble is 1. It saturates at 2^CNT_W-1.
- flush_count increments on each redirect and saturates.
- Reset asserted mid-MEM_WAIT: outputs drop immediately and state returns to RUN.

Test Plan:
- Load r3 in act, dcache_ready=0 for 3 cycles then 1 -> 3 cycles of pc_stall/i2d_stall/d2a_stall/a2w_bubble=1. state=1 on cycles 2-4. Cycle 4 controls=0, then state=0. stall_cycles=3.
- Load r5 with ready=1 in same cycle, decode dec_rs1_valid=1 dec_rs1=5 -> one cycle pc_stall=i2d_stall=d2a_bubble=1. Repeat with dec_rs1=6 -> no stall.
- act_branch_taken=1 with a valid load-use hit also present -> redirect=i2d_flush=d2a_bubble=1, pc_stall=0. flush_count increments by 1.
- MEM_TIMEOUT=4, dcache_ready held 0 -> ERR after 4 MEM_WAIT cycles, timeout_err=1. It stays set when ready later rises and clears only on n_rst.
- Assert n_rst=0 mid-MEM_WAIT, asynchronous to clk -> controls 0 immediately, state=0, counters=0.
- CNT_W=4 with continuous stalls for 20 cycles -> stall_cycles saturates at 15.
